// File: rtl/wac_adc_emu_if.sv
// Serial link between the WAC ADC controller (master) and one converter channel (slave).
interface wac_adc_emu_if;
  logic CSADC;
  logic CLKADC;
  logic SDOADC;

  modport master (output CSADC, output CLKADC, input SDOADC);
  modport slave  (input CSADC, input CLKADC, output SDOADC);
endinterface

// File: rtl/wac_adc_emu.sv
// Behavioural WAC ADC responder: serves 12-bit samples from a FIFO as 16-bit frames on SDOADC.
// Optional macro WAC_ADC_EMU_RAMP_EN: an empty-FIFO pop supplies a 12-bit ramp instead of the last sample.
module wac_adc_emu #(
  parameter int DEPTH_LOG2 = 3,
  parameter int FRAME_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  wac_adc_emu_if.slave          adc,
  input  logic [11:0]           sampleIn,
  input  logic                  sampleStb,
  output logic [DEPTH_LOG2:0]   fifoLevel,
  output logic                  busy,
  output logic                  frameDone,
  output logic                  frameErr,
  output logic                  underrun,
  output logic                  overflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam int CW    = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state, stateNxt;
  logic [2:0]              csSync, ckSync;
  logic                    csFall, csRise, ckFall;
  logic                    popEn, shEn, doneNxt, errNxt;
  logic [FRAME_BITS-1:0]   shreg;
  logic [CW-1:0]           bitCnt;
  logic [11:0]             mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wrPtr, rdPtr;
  logic                    empty, full, popHit, wrAcc;
  logic [11:0]             fallback, popData;

  // Stage [2] is the edge-detect reference behind the two synchronizer flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      csSync <= 3'b111;
      ckSync <= 3'b000;
    end else begin
      csSync <= {csSync[1:0], adc.CSADC};
      ckSync <= {ckSync[1:0], adc.CLKADC};
    end
  end

  assign csFall = csSync[2] & ~csSync[1];
  assign csRise = ~csSync[2] & csSync[1];
  assign ckFall = ckSync[2] & ~ckSync[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    popEn    = 1'b0;
    shEn     = 1'b0;
    doneNxt  = 1'b0;
    errNxt   = 1'b0;
    case (state)
      IDLE: if (csFall) begin
        popEn    = 1'b1;
        stateNxt = SHIFT;
      end
      SHIFT: begin
        shEn = ckFall;
        // A CS rise coinciding with the last fall still counts as a good frame.
        if (ckFall && bitCnt == CW'(FRAME_BITS - 1)) begin
          doneNxt  = 1'b1;
          stateNxt = csRise ? IDLE : DONE;
        end else if (csRise) begin
          errNxt   = 1'b1;
          stateNxt = IDLE;
        end
      end
      DONE: if (csRise) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  assign empty   = (fifoLevel == '0);
  assign full    = (fifoLevel == LW'(DEPTH));
  assign popHit  = popEn & ~empty;
  assign wrAcc   = sampleStb & (~full | popEn);
  assign popData = empty ? fallback : mem[rdPtr];

  always_ff @(posedge clk) begin
    if (wrAcc) mem[wrPtr] <= sampleIn;
  end

`ifdef WAC_ADC_EMU_RAMP_EN
  logic [11:0] ramp;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              ramp <= '0;
    else if (popEn & empty) ramp <= ramp + 12'd1;
  end
  assign fallback = ramp;
`else
  logic [11:0] lastSample;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       lastSample <= '0;
    else if (popHit) lastSample <= popData;
  end
  assign fallback = lastSample;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifoLevel <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      shreg     <= '0;
      bitCnt    <= '0;
      frameDone <= 1'b0;
      frameErr  <= 1'b0;
      underrun  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      fifoLevel <= fifoLevel + LW'(wrAcc) - LW'(popHit);
      if (wrAcc)  wrPtr <= wrPtr + 1'b1;
      if (popHit) rdPtr <= rdPtr + 1'b1;
      if (popEn) begin
        shreg  <= {{(FRAME_BITS-12){1'b0}}, popData};
        bitCnt <= '0;
      end else if (shEn) begin
        shreg  <= shreg << 1;
        bitCnt <= bitCnt + 1'b1;
      end
      frameDone <= doneNxt;
      frameErr  <= errNxt;
      underrun  <= popEn & empty;
      overflow  <= sampleStb & ~wrAcc;
    end
  end

  assign adc.SDOADC = (state == SHIFT) & shreg[FRAME_BITS-1];
  assign busy       = (state != IDLE);
endmodule
